// File: rtl/load_store_pkg.sv
// Shared types and defaults for the multi-channel load/store level generator.
//   dir_e      : per-channel ramp state (FALL, RISE, and HOLD for dwell builds)
//   *_DEF      : default level width, reset high bound and step width
//   chan_cfg_t : one channel's {lo, hi, step} at the default widths
// Optional feature macro: DWELL_EN (adds the HOLD state in load_store_chan).
package load_store_pkg;

    localparam int CBITS_DEF  = 15;
    localparam int N_DEF      = 20000;
    localparam int STEP_W_DEF = 8;

    typedef enum logic [1:0] {
        FALL = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2
    } dir_e;

    typedef struct packed {
        logic [CBITS_DEF-1:0]  lo;
        logic [CBITS_DEF-1:0]  hi;
        logic [STEP_W_DEF-1:0] step;
    } chan_cfg_t;

endpackage

// File: rtl/multi_load_store_if.sv
// Configuration port of multi_load_store.
//   cfg_we   : write strobe, one write per cycle it is high
//   cfg_ch   : target channel
//   cfg_lo   : new low bound
//   cfg_hi   : new high bound
//   cfg_step : new step
//   cfg_err  : registered one-cycle pulse, the write of the previous cycle was rejected
// Handshake: there is no backpressure. Every cycle with cfg_we=1 is one write
// attempt; it is either accepted (config stored at that edge) or rejected, in
// which case cfg_err is high for exactly the following cycle.
interface multi_load_store_if #(
    parameter int NCH    = 4,
    parameter int CBITS  = 15,
    parameter int STEP_W = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              cfg_we;
    logic [CHW-1:0]    cfg_ch;
    logic [CBITS-1:0]  cfg_lo;
    logic [CBITS-1:0]  cfg_hi;
    logic [STEP_W-1:0] cfg_step;
    logic              cfg_err;

    modport master (output cfg_we, cfg_ch, cfg_lo, cfg_hi, cfg_step, input cfg_err);
    modport slave  (input cfg_we, cfg_ch, cfg_lo, cfg_hi, cfg_step, output cfg_err);
endinterface

// File: rtl/load_store_chan.sv
// One channel of the level generator: ramp state machine, saturating step
// arithmetic and (with DWELL_EN) the dwell counter at the high bound.
//   clk, rst   : clock, synchronous active-high reset
//   en_i       : advance enable
//   reclamp_i  : clamp level into the (new) bounds this cycle instead of stepping
//   cfg_wr_i   : config accepted for this channel this cycle (clears dwell)
//   lo_i/hi_i/step_i : current config
//   vol_o, dir_o, sig_o, bot_o : registered level, rising flag, at-hi, at-lo
//   state_o    : debug view of the state register
// Optional feature macro: DWELL_EN.
module load_store_chan
    import load_store_pkg::*;
#(
    parameter int CBITS  = CBITS_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int DWELL  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              reclamp_i,
    input  logic              cfg_wr_i,
    input  logic [CBITS-1:0]  lo_i,
    input  logic [CBITS-1:0]  hi_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [CBITS-1:0]  vol_o,
    output logic              dir_o,
    output logic              sig_o,
    output logic              bot_o,
    output dir_e              state_o
);
    localparam int XW = CBITS + 1;

    dir_e             state_q, state_d;
    logic [CBITS-1:0] vol_q, vol_d;
    logic             sig_q, sig_d, bot_q, bot_d;
    logic [XW-1:0]    vol_x, sum_x, diff_x;
    logic [CBITS-1:0] up_val, dn_val, clamp_val;
    logic             upd;

`ifdef DWELL_EN
    localparam int DW = $clog2(DWELL + 2);
    logic [DW-1:0] cnt_q, cnt_d;
`endif

    // One extra bit keeps vol+step and vol-step from wrapping; a set top bit
    // on the difference means it went below zero.
    assign vol_x  = {1'b0, vol_q};
    assign sum_x  = vol_x + XW'(step_i);
    assign diff_x = vol_x - XW'(step_i);

    assign up_val    = (sum_x > {1'b0, hi_i}) ? hi_i : sum_x[CBITS-1:0];
    assign dn_val    = (diff_x[CBITS] || (diff_x < {1'b0, lo_i})) ? lo_i : diff_x[CBITS-1:0];
    assign clamp_val = (vol_q < lo_i) ? lo_i : ((vol_q > hi_i) ? hi_i : vol_q);

    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        sig_d   = sig_q;
        bot_d   = bot_q;
        upd     = 1'b0;
`ifdef DWELL_EN
        cnt_d   = cnt_q;
`endif
        if (reclamp_i) begin
            vol_d = clamp_val;
            upd   = 1'b1;
        end else if (en_i) begin
            upd = 1'b1;
            unique case (state_q)
                RISE: begin
                    if (vol_q >= hi_i) begin
`ifdef DWELL_EN
                        // The turn-around cycle counts as the first dwell cycle.
                        state_d = HOLD;
                        cnt_d   = DW'(1);
`else
                        state_d = FALL;
`endif
                    end else begin
                        vol_d = up_val;
                    end
                end
                HOLD: begin
`ifdef DWELL_EN
                    if (cnt_q >= DW'(DWELL)) state_d = FALL;
                    else                     cnt_d   = cnt_q + DW'(1);
`else
                    state_d = FALL;
`endif
                end
                default: begin
                    if (vol_q <= lo_i) state_d = RISE;
                    else               vol_d   = dn_val;
                end
            endcase
        end
        if (upd) begin
            sig_d = (vol_d == hi_i);
            bot_d = (vol_d == lo_i);
        end
`ifdef DWELL_EN
        if (cfg_wr_i) cnt_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FALL;
            vol_q   <= '0;
            sig_q   <= 1'b0;
            bot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            sig_q   <= sig_d;
            bot_q   <= bot_d;
        end
    end

`ifdef DWELL_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_wr;
    assign unused_wr = cfg_wr_i;
`endif

    assign vol_o   = vol_q;
    assign dir_o   = (state_q == RISE);
    assign sig_o   = sig_q;
    assign bot_o   = bot_q;
    assign state_o = state_q;
endmodule

// File: rtl/multi_load_store.sv
// Multi-channel load/store level generator. Owns per-channel config storage,
// write validation and cfg_err; instantiates NCH load_store_chan copies.
//   clk, rst    : clock, synchronous active-high reset
//   en          : per-channel advance enable
//   cfg         : configuration port (multi_load_store_if.slave)
//   vol         : levels, channel i at [i*CBITS +: CBITS]
//   dir/sig/bot : per-channel rising / at-hi / at-lo flags
//   dbg_state_o : channel state registers, channel i at [2*i +: 2]
// Optional feature macro: DWELL_EN (hold DWELL enabled cycles at hi).
module multi_load_store
    import load_store_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CBITS  = CBITS_DEF,
    parameter int N      = N_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int DWELL  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    multi_load_store_if.slave    cfg,
    output logic [NCH*CBITS-1:0] vol,
    output logic [NCH-1:0]       dir,
    output logic [NCH-1:0]       sig,
    output logic [NCH-1:0]       bot,
    output logic [2*NCH-1:0]     dbg_state_o
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic [CBITS-1:0]  lo;
        logic [CBITS-1:0]  hi;
        logic [STEP_W-1:0] step;
    } cfg_t;

    cfg_t           cfg_q [NCH];
    cfg_t           cfg_d [NCH];
    logic [NCH-1:0] hit, wr_sel, reclamp_q;
    logic           fields_ok, accept, err_d, err_q;

    // Channel decode doubles as the cfg_ch < NCH range check.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++) hit[i] = (cfg.cfg_ch == CHW'(i));
        fields_ok = (cfg.cfg_lo < cfg.cfg_hi) && (cfg.cfg_step != '0);
        accept    = cfg.cfg_we && (|hit) && fields_ok;
        err_d     = cfg.cfg_we && !accept;
        wr_sel    = accept ? hit : '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_d[i] = cfg_q[i];
            if (wr_sel[i]) cfg_d[i] = '{lo: cfg.cfg_lo, hi: cfg.cfg_hi, step: cfg.cfg_step};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cfg_q[i] <= '{lo: '0, hi: CBITS'(N), step: STEP_W'(1)};
            reclamp_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) cfg_q[i] <= cfg_d[i];
            // The channel steps with its old config in the write cycle and
            // reclamps into the new bounds on the cycle after.
            reclamp_q <= wr_sel;
            err_q     <= err_d;
        end
    end

    assign cfg.cfg_err = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        dir_e st;
        load_store_chan #(
            .CBITS (CBITS),
            .STEP_W(STEP_W),
            .DWELL (DWELL)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en_i     (en[g]),
            .reclamp_i(reclamp_q[g]),
            .cfg_wr_i (wr_sel[g]),
            .lo_i     (cfg_q[g].lo),
            .hi_i     (cfg_q[g].hi),
            .step_i   (cfg_q[g].step),
            .vol_o    (vol[g*CBITS +: CBITS]),
            .dir_o    (dir[g]),
            .sig_o    (sig[g]),
            .bot_o    (bot[g]),
            .state_o  (st)
        );
        assign dbg_state_o[2*g +: 2] = st;
    end
endmodule

// File: tb/tb_multi_load_store.sv
// Randomized and directed stimulus for multi_load_store, checked by a
// scoreboard against a behavioural model of the ramp rules.
module tb_multi_load_store;
    localparam int NCH    = 4;
    localparam int CBITS  = 15;
    localparam int N      = 20000;
    localparam int STEP_W = 8;
    localparam int DWELL  = 3;
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic [NCH*CBITS-1:0] vol;
        logic [NCH-1:0]       dir;
        logic [NCH-1:0]       sig;
        logic [NCH-1:0]       bot;
        logic                 err;
    } exp_t;
    localparam int EW = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH*CBITS-1:0] vol;
    logic [NCH-1:0]       dir, sig, bot;
    logic [2*NCH-1:0]     dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    multi_load_store_if #(.NCH(NCH), .CBITS(CBITS), .STEP_W(STEP_W)) cfg_if ();

    multi_load_store #(
        .NCH(NCH), .CBITS(CBITS), .N(N), .STEP_W(STEP_W), .DWELL(DWELL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg_if),
        .vol        (vol),
        .dir        (dir),
        .sig        (sig),
        .bot        (bot),
        .dbg_state_o(dbg_state)
    );

    // ---------------- reference model ----------------
    // m_ph: 0 = falling, 1 = rising, 2 = holding at hi
    int  m_vol [NCH];
    int  m_ph  [NCH];
    int  m_cnt [NCH];
    int  m_lo  [NCH];
    int  m_hi  [NCH];
    int  m_step[NCH];
    bit  m_recl[NCH];
    bit  m_sig [NCH];
    bit  m_bot [NCH];
    bit  m_err;

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic model_step(bit r, bit [NCH-1:0] e, bit we, int ch, int lo, int hi, int st);
        bit acc, upd;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_vol[i] = 0; m_ph[i] = 0; m_cnt[i] = 0;
                m_lo[i] = 0; m_hi[i] = N; m_step[i] = 1;
                m_recl[i] = 0; m_sig[i] = 0; m_bot[i] = 0;
            end
            m_err = 0;
            return;
        end
        acc   = we && (ch < NCH) && (lo < hi) && (st != 0);
        m_err = we && !acc;
        for (int i = 0; i < NCH; i++) begin
            upd = 0;
            if (m_recl[i]) begin
                m_vol[i] = imin(imax(m_vol[i], m_lo[i]), m_hi[i]);
                upd = 1;
            end else if (e[i]) begin
                upd = 1;
                if (m_ph[i] == 1) begin
                    if (m_vol[i] >= m_hi[i]) begin
`ifdef DWELL_EN
                        m_ph[i] = 2; m_cnt[i] = 1;
`else
                        m_ph[i] = 0;
`endif
                    end else m_vol[i] = imin(m_vol[i] + m_step[i], m_hi[i]);
                end else if (m_ph[i] == 2) begin
                    if (m_cnt[i] >= DWELL) m_ph[i] = 0;
                    else m_cnt[i]++;
                end else begin
                    if (m_vol[i] <= m_lo[i]) m_ph[i] = 1;
                    else m_vol[i] = imax(m_vol[i] - m_step[i], m_lo[i]);
                end
            end
            if (upd) begin
                m_sig[i] = (m_vol[i] == m_hi[i]);
                m_bot[i] = (m_vol[i] == m_lo[i]);
            end
        end
        for (int i = 0; i < NCH; i++) m_recl[i] = acc && (ch == i);
        if (acc) begin
            m_lo[ch] = lo; m_hi[ch] = hi; m_step[ch] = st; m_cnt[ch] = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int vectors;
    int miscompares;

    // ---------------- driver ----------------
    task automatic drive(bit r, bit [NCH-1:0] e, bit we, int ch, int lo, int hi, int st);
        exp_t x;
        @(negedge clk);
        rst             = r;
        en              = e;
        cfg_if.cfg_we   = we;
        cfg_if.cfg_ch   = ch[CHW-1:0];
        cfg_if.cfg_lo   = lo[CBITS-1:0];
        cfg_if.cfg_hi   = hi[CBITS-1:0];
        cfg_if.cfg_step = st[STEP_W-1:0];
        model_step(r, e, we, ch, lo, hi, st);
        for (int i = 0; i < NCH; i++) begin
            x.vol[i*CBITS +: CBITS] = m_vol[i][CBITS-1:0];
            x.dir[i] = (m_ph[i] == 1);
            x.sig[i] = m_sig[i];
            x.bot[i] = m_bot[i];
        end
        x.err = m_err;
        exp_q.push_back(x);
    endtask

    task automatic idle(bit [NCH-1:0] e, int cycles);
        for (int k = 0; k < cycles; k++) drive(0, e, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(int cycles);
        for (int k = 0; k < cycles; k++) drive(1, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_phase(int cycles);
        bit r, we;
        bit [NCH-1:0] e;
        int ch, lo, hi, st;
        for (int k = 0; k < cycles; k++) begin
            r  = ($urandom_range(0, 599) == 0);
            e  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            we = ($urandom_range(0, 9) == 0);
            ch = $urandom_range(0, NCH - 1);
            lo = $urandom_range(0, 300);
            hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 300) : lo + $urandom_range(1, 400);
            st = $urandom_range(0, 40);
            drive(r, e, we, ch, lo, hi, st);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e     = exp_t'(exp_q.pop_front());
                g.vol = vol;
                g.dir = dir;
                g.sig = sig;
                g.bot = bot;
                g.err = cfg_if.cfg_err;
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard vec=%0d got vol=%h dir=%b sig=%b bot=%b err=%b exp vol=%h dir=%b sig=%b bot=%b err=%b",
                             vectors, g.vol, g.dir, g.sig, g.bot, g.err, e.vol, e.dir, e.sig, e.bot, e.err);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        en = '0;
        cfg_if.cfg_we = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_lo = '0;
        cfg_if.cfg_hi = '0;
        cfg_if.cfg_step = '0;

        // Small ramp lo=0 hi=5 step=2 on channel 0.
        do_reset(2);
        drive(0, '0, 1, 0, 0, 5, 2);
        idle('0, 1);
        idle(4'b0001, 12);

        // Rejected writes: lo > hi, step 0, lo == hi.
        drive(0, '0, 1, 1, 100, 50, 1);
        idle('0, 1);
        drive(0, '0, 1, 1, 0, 50, 0);
        drive(0, '0, 1, 1, 50, 50, 3);
        idle(4'b0010, 3);

        // Default config, full ramp to N and turn-around.
        do_reset(1);
        idle('1, N + 6);

        // Channel 2 at 300, then shrink bounds below the level.
        do_reset(1);
        idle(4'b0100, 301);
        drive(0, 4'b0100, 1, 2, 0, 200, 1);
        idle(4'b0100, 300);

        // Freeze channel 3 mid-ramp.
        do_reset(1);
        idle('1, 50);
        idle(4'b0111, 5);
        idle('1, 20);

        // Short dwell ramp, then reset mid-dwell.
        do_reset(1);
        drive(0, '0, 1, 0, 0, 4, 4);
        idle('0, 1);
        idle(4'b0001, 4);
        do_reset(1);
        idle(4'b0001, 10);

        random_phase(3000);

        // Drain: every pushed expectation must be consumed within a few cycles.
        idle('0, 2);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
